tilegen_bus_master: RTL and testbench

CPU-side write initiator for the tile generator's bus port. It accepts buffered write commands through a valid/ready handshake. It then drives the TILEGEN select strobes (SCROLL0/1, LATCH0/1), address A, data MD and a single-cycle WE pulse, each aligned to the CPU access slot given by CLK_2H. It sits between the system CPU/bus model (or a bench sequencer) and TILEGEN, and replaces hand-timed stimulus with a cycle-exact write engine.

---
 rtl/tilegen_bus_master.sv | 191 +++++++++++++++++++
 tb/tb_tilegen_bus_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tilegen_bus_master.sv
// rtl/tilegen_bus_master.sv - CPU-side write initiator for the TILEGEN bus port
//
// Buffers write commands in a small FIFO and replays each one as a
// cycle-exact TILEGEN write aligned to the CPU slot marked by CLK_2H:
// SETUP (address, data, select) -> STROBE (WE=1) -> HOLD.
//
// Ports:
//   CLK_6M, RST        pixel clock, synchronous active-high reset
//   CLK_2H             2H phase; a rising edge opens a CPU access slot
//   cmd_valid/ready    command handshake (accept on valid && ready)
//   cmd_target         0=SCROLL0 1=SCROLL1 2=LATCH0 3=LATCH1
//   cmd_addr/cmd_data  write address / data
//   SCROLL0..LATCH1    one-hot target select
//   A, MD, WE          address, data, single-cycle write strobe
//   busy               FIFO non-empty or a write in flight
module tilegen_bus_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8
) (
  input  logic              CLK_6M,
  input  logic              RST,
  input  logic              CLK_2H,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_target,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              SCROLL0,
  output logic              SCROLL1,
  output logic              LATCH0,
  output logic              LATCH1,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] MD,
  output logic              WE,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 + ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SLOT,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  // 2H rising-edge detect
  logic h2_q;
  logic slot;
  assign slot = CLK_2H && !h2_q;

  // Command FIFO
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  logic             push, pop;

  assign push = cmd_valid && ready_q;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK_6M) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      h2_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      // ready comes straight from next occupancy so it is a clean register output
      ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
      h2_q    <= CLK_2H;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge CLK_6M) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_target, cmd_addr, cmd_data};
  end

  // Working registers: command currently being issued
  logic [1:0]        wtgt_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  always_ff @(posedge CLK_6M) begin
    if (RST) begin
      wtgt_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (pop) begin
      {wtgt_q, waddr_q, wdata_q} <= mem_q[rd_ptr_q];
    end
  end

  // FSM: state register
  always_ff @(posedge CLK_6M) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (count_q != '0) state_d = S_WAIT_SLOT;
      S_WAIT_SLOT: if (slot) state_d = S_SETUP;
      S_SETUP:     state_d = S_STROBE;
      S_STROBE:    state_d = S_HOLD;
      S_HOLD:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FSM: outputs, decoded from the next state so every output is registered
  logic [3:0]        sel_d, sel_q;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] a_d, a_q;
  logic [DATA_W-1:0] md_d, md_q;
  logic              busy_d, busy_q;

  always_comb begin
    sel_d  = '0;
    we_d   = 1'b0;
    a_d    = a_q;
    md_d   = md_q;
    busy_d = (count_d != '0) || (state_d != S_IDLE);
    case (state_d)
      S_SETUP: begin
        sel_d = 4'b0001 << wtgt_q;
        a_d   = waddr_q;
        md_d  = wdata_q;
      end
      S_STROBE: begin
        sel_d = 4'b0001 << wtgt_q;
        we_d  = 1'b1;
      end
      S_HOLD: begin
        sel_d = 4'b0001 << wtgt_q;
      end
      default: begin
        sel_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_6M) begin
    if (RST) begin
      sel_q  <= '0;
      we_q   <= 1'b0;
      a_q    <= '0;
      md_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      we_q   <= we_d;
      a_q    <= a_d;
      md_q   <= md_d;
      busy_q <= busy_d;
    end
  end

  assign SCROLL0   = sel_q[0];
  assign SCROLL1   = sel_q[1];
  assign LATCH0    = sel_q[2];
  assign LATCH1    = sel_q[3];
  assign WE        = we_q;
  assign A         = a_q;
  assign MD        = md_q;
  assign busy      = busy_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_tilegen_bus_master.sv
// tb/tb_tilegen_bus_master.sv - directed self-checking bench for tilegen_bus_master
module tb_tilegen_bus_master;

  logic        CLK_6M = 1'b0;
  logic        RST = 1'b1;
  logic        CLK_2H = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_target = '0;
  logic [12:0] cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        SCROLL0, SCROLL1, LATCH0, LATCH1;
  logic [12:0] A;
  logic [7:0]  MD;
  logic        WE;
  logic        busy;

  tilegen_bus_master #(.FIFO_DEPTH(4), .ADDR_W(13), .DATA_W(8)) dut (
    .CLK_6M(CLK_6M), .RST(RST), .CLK_2H(CLK_2H),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .SCROLL0(SCROLL0), .SCROLL1(SCROLL1), .LATCH0(LATCH0), .LATCH1(LATCH1),
    .A(A), .MD(MD), .WE(WE), .busy(busy)
  );

  always #5 CLK_6M = ~CLK_6M;

  logic [3:0] sel;
  assign sel = {LATCH1, LATCH0, SCROLL1, SCROLL0};

  // 2H source: free-running counter bit 1, or a forced level
  logic       h2_auto = 1'b1;
  logic       h2_force = 1'b0;
  logic [7:0] h2_cnt = '0;
  always @(negedge CLK_6M) begin
    h2_cnt = h2_cnt + 8'd1;
    CLK_2H = h2_auto ? h2_cnt[1] : h2_force;
  end

  // CLK_2H as seen at the previous two rising edges
  logic [1:0] h_hist = '0;
  always @(posedge CLK_6M) h_hist <= {h_hist[0], CLK_2H};

  int cyc = 0;
  always @(posedge CLK_6M) cyc <= cyc + 1;

  int          we_cnt = 0;
  int          we_cyc[$];
  logic [12:0] we_a[$];
  logic [7:0]  we_md[$];
  always @(negedge CLK_6M) begin
    if (WE) begin
      we_cnt = we_cnt + 1;
      we_cyc.push_back(cyc);
      we_a.push_back(A);
      we_md.push_back(MD);
    end
  end

  int n_total = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_6M);
    #1;
  endtask

  task automatic push(input logic [1:0] tgt, input logic [12:0] addr, input logic [7:0] data);
    int n;
    n = 0;
    cmd_target = tgt;
    cmd_addr   = addr;
    cmd_data   = data;
    cmd_valid  = 1'b1;
    while (!cmd_ready && n < 40) begin
      tick();
      n++;
    end
    check("push_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // One command from an idle engine: checks the full SETUP/STROBE/HOLD/idle sequence
  task automatic write_check(input logic [1:0] tgt, input logic [12:0] addr, input logic [7:0] data);
    int n;
    logic [3:0] exp_sel;
    exp_sel = 4'b0001 << tgt;
    push(tgt, addr, data);
    n = 0;
    while (sel == 4'b0 && n < 12) begin
      tick();
      n++;
    end
    check("setup_seen", (sel != 4'b0), 1'b1);
    check("setup_sel", sel, exp_sel);
    check("setup_we", WE, 1'b0);
    check("setup_a", A, addr);
    check("setup_md", MD, data);
    check("slot_align", h_hist, 2'b01);
    tick();
    check("strobe_sel", sel, exp_sel);
    check("strobe_we", WE, 1'b1);
    check("strobe_a", A, addr);
    tick();
    check("hold_sel", sel, exp_sel);
    check("hold_we", WE, 1'b0);
    check("hold_md", MD, data);
    tick();
    check("after_sel", sel, 4'b0);
    check("after_we", WE, 1'b0);
    check("after_busy", busy, 1'b0);
    check("after_a_held", A, addr);
  endtask

  initial begin
    int n;
    int base;
    logic seen;

    // Reset with cmd_valid held high
    RST = 1'b1;
    cmd_valid = 1'b1;
    cmd_data = 8'hAA;
    tick();
    tick();
    check("rst_sel", sel, 4'b0);
    check("rst_we", WE, 1'b0);
    check("rst_a", A, 13'h0);
    check("rst_md", MD, 8'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b0;
    RST = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("rst_no_accept_busy", busy, 1'b0);
    check("rst_no_we", we_cnt, 0);

    // Single write and every target
    write_check(2'd0, 13'h0000, 8'h5A);
    write_check(2'd1, 13'h1FFF, 8'hFF);
    write_check(2'd2, 13'h1FFF, 8'hFF);
    write_check(2'd3, 13'h1FFF, 8'hFF);
    check("targets_we_count", we_cnt, 4);

    // FIFO fill: five back-to-back commands
    we_cyc.delete();
    we_a.delete();
    we_md.delete();
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_target = 2'(i);
      cmd_addr   = 13'h0100 + 13'(i);
      cmd_data   = 8'h10 + 8'(i);
      check("fill_ready", cmd_ready, 1'b1);
      tick();
    end
    cmd_valid = 1'b0;
    check("fill_full", cmd_ready, 1'b0);
    check("fill_busy", busy, 1'b1);
    n = 0;
    while (busy && n < 80) begin
      tick();
      n++;
    end
    check("fill_drained", busy, 1'b0);
    check("fill_we_count", we_a.size(), 5);
    if (we_a.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("fill_a", we_a[i], 13'h0100 + 13'(i));
        check("fill_md", we_md[i], 8'h10 + 8'(i));
        if (i > 0)
          check("fill_gap", ((we_cyc[i] - we_cyc[i-1]) % 4 == 0) &&
                (we_cyc[i] - we_cyc[i-1] >= 4) && (we_cyc[i] - we_cyc[i-1] <= 8), 1'b1);
      end
    end
    check("fill_ready_back", cmd_ready, 1'b1);

    // Reset during STROBE with commands queued
    push(2'd1, 13'h0AAA, 8'h11);
    push(2'd2, 13'h0BBB, 8'h22);
    push(2'd3, 13'h0CCC, 8'h33);
    n = 0;
    while (!WE && n < 20) begin
      tick();
      n++;
    end
    check("mid_we_seen", WE, 1'b1);
    RST = 1'b1;
    tick();
    check("mid_rst_we", WE, 1'b0);
    check("mid_rst_sel", sel, 4'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", cmd_ready, 1'b1);
    check("mid_rst_a", A, 13'h0);
    RST = 1'b0;
    base = we_cnt;
    for (int i = 0; i < 30; i++) tick();
    check("mid_no_more_we", we_cnt, base);
    check("mid_busy_idle", busy, 1'b0);

    // No slot while CLK_2H is held low
    h2_force = 1'b0;
    h2_auto  = 1'b0;
    tick();
    tick();
    push(2'd2, 13'h0123, 8'h45);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sel != 4'b0 || WE) seen = 1'b1;
    end
    check("noslot_no_strobe", seen, 1'b0);
    check("noslot_busy", busy, 1'b1);
    h2_force = 1'b1;
    @(negedge CLK_6M);
    tick();
    check("slot_setup_sel", sel, 4'b0100);
    check("slot_setup_we", WE, 1'b0);
    check("slot_setup_a", A, 13'h0123);
    tick();
    check("slot_strobe_we", WE, 1'b1);
    tick();
    tick();
    check("slot_done_sel", sel, 4'b0);
    check("slot_done_busy", busy, 1'b0);
    h2_auto = 1'b1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
